// File: rtl/cpu_pkg.sv
// Shared definitions for the load-side memory stage: LW variant encoding,
// load-type bundle and the stage FSM encoding.
package cpu_pkg;

  localparam logic [1:0] LW_NONE  = 2'b00;
  localparam logic [1:0] LW_RIGHT = 2'b01;
  localparam logic [1:0] LW_LEFT  = 2'b10;
  localparam logic [1:0] LW_WORD  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic       lb;
    logic       lbu;
    logic       lh;
    logic       lhu;
    logic [1:0] lw;
  } load_type_t;

  function automatic logic is_load(input logic mem_en, input logic mem_to_reg);
    return mem_en & mem_to_reg;
  endfunction

endpackage

// File: rtl/Load_sel.sv
// Aligns and extends a returned SRAM word for the load types, and merges
// the old rt value for the unaligned LWL/LWR pair.
module Load_sel
  import cpu_pkg::*;
(
  input  logic [1:0]  vaddr,
  input  load_type_t  ltype,
  input  logic [31:0] data_rdata,
  input  logic [31:0] rt,
  output logic [31:0] data,
  output logic [3:0]  byte_en
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = data_rdata[7:0];
    case (vaddr)
      2'd1:    byte_val = data_rdata[15:8];
      2'd2:    byte_val = data_rdata[23:16];
      2'd3:    byte_val = data_rdata[31:24];
      default: byte_val = data_rdata[7:0];
    endcase
    // odd halfword offsets never reach here (address error raised upstream)
    half_val = vaddr[1] ? data_rdata[31:16] : data_rdata[15:0];
  end

  always_comb begin
    data    = data_rdata;
    byte_en = 4'b1111;
    if (ltype.lb) begin
      data = {{24{byte_val[7]}}, byte_val};
    end else if (ltype.lbu) begin
      data = {24'h0, byte_val};
    end else if (ltype.lh) begin
      data = {{16{half_val[15]}}, half_val};
    end else if (ltype.lhu) begin
      data = {16'h0, half_val};
    end else if (ltype.lw == LW_LEFT) begin
      case (vaddr)
        2'd0: begin data = {data_rdata[7:0],  rt[23:0]}; byte_en = 4'b1000; end
        2'd1: begin data = {data_rdata[15:0], rt[15:0]}; byte_en = 4'b1100; end
        2'd2: begin data = {data_rdata[23:0], rt[7:0]};  byte_en = 4'b1110; end
        default: begin data = data_rdata; byte_en = 4'b1111; end
      endcase
    end else if (ltype.lw == LW_RIGHT) begin
      case (vaddr)
        2'd1: begin data = {rt[31:24], data_rdata[31:8]};  byte_en = 4'b0111; end
        2'd2: begin data = {rt[31:16], data_rdata[31:16]}; byte_en = 4'b0011; end
        2'd3: begin data = {rt[31:8],  data_rdata[31:24]}; byte_en = 4'b0001; end
        default: begin data = data_rdata; byte_en = 4'b1111; end
      endcase
    end
  end

endmodule

// File: rtl/memory_load_stage.sv
// Load-side MEM stage: waits for the SRAM read response, aligns it and
// registers the WB fields. ST_IDLE | accepting; ST_WAIT | load outstanding.
module memory_load_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_EXE_MEM,
  output logic        ready_MEM,
  input  logic        MemEn_EXE_MEM,
  input  logic        MemToReg_EXE_MEM,
  input  logic [3:0]  RegWrite_EXE_MEM,
  input  logic [4:0]  RegWaddr_EXE_MEM,
  input  logic [31:0] ALUResult_EXE_MEM,
  input  logic [31:0] RegRdata2_EXE_MEM,
  input  logic        LB_EXE_MEM,
  input  logic        LBU_EXE_MEM,
  input  logic        LH_EXE_MEM,
  input  logic        LHU_EXE_MEM,
  input  logic [1:0]  LW_EXE_MEM,
  input  logic        data_rvalid,
  input  logic [31:0] data_rdata,
  output logic        valid_MEM_WB,
  output logic [3:0]  RegWrite_MEM_WB,
  output logic [4:0]  RegWaddr_MEM_WB,
  output logic [31:0] RegWdata_MEM_WB,
  output logic        load_pending_MEM,
  output logic [4:0]  PendWaddr_MEM
);

  mem_state_t state, state_next;
  logic       accept, accept_load, load_done;
  logic [1:0] off_q;
  logic [31:0] rt_q;
  load_type_t type_q;
  logic [31:0] sel_data;
  logic [3:0]  sel_en;

  assign ready_MEM        = (state == ST_IDLE);
  assign load_pending_MEM = (state == ST_WAIT);
  assign accept           = ready_MEM & valid_EXE_MEM;
  assign accept_load      = accept & is_load(MemEn_EXE_MEM, MemToReg_EXE_MEM);
  assign load_done        = (state == ST_WAIT) & data_rvalid;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept_load) state_next = ST_WAIT;
      ST_WAIT: if (data_rvalid) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // load descriptor held while the response is outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      off_q         <= 2'b00;
      rt_q          <= 32'h0;
      type_q        <= '0;
      PendWaddr_MEM <= 5'd0;
    end else if (accept_load) begin
      off_q         <= ALUResult_EXE_MEM[1:0];
      rt_q          <= RegRdata2_EXE_MEM;
      type_q        <= '{lb: LB_EXE_MEM, lbu: LBU_EXE_MEM, lh: LH_EXE_MEM,
                         lhu: LHU_EXE_MEM, lw: LW_EXE_MEM};
      PendWaddr_MEM <= RegWaddr_EXE_MEM;
    end
  end

  Load_sel u_load_sel (
    .vaddr      (off_q),
    .ltype      (type_q),
    .data_rdata (data_rdata),
    .rt         (rt_q),
    .data       (sel_data),
    .byte_en    (sel_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_MEM_WB    <= 1'b0;
      RegWrite_MEM_WB <= 4'h0;
      RegWaddr_MEM_WB <= 5'd0;
      RegWdata_MEM_WB <= 32'h0;
    end else begin
      valid_MEM_WB <= 1'b0;
      if (load_done) begin
        valid_MEM_WB    <= 1'b1;
        RegWrite_MEM_WB <= sel_en;
        RegWaddr_MEM_WB <= PendWaddr_MEM;
        RegWdata_MEM_WB <= sel_data;
      end else if (accept && !accept_load) begin
        valid_MEM_WB    <= 1'b1;
        RegWrite_MEM_WB <= RegWrite_EXE_MEM;
        RegWaddr_MEM_WB <= RegWaddr_EXE_MEM;
        RegWdata_MEM_WB <= ALUResult_EXE_MEM;
      end
    end
  end

endmodule

// File: tb/tb_memory_load_stage.sv
// Bench for memory_load_stage: transaction-level model compared every cycle,
// plus directed loads with hand-computed WB values.
module tb_memory_load_stage;

  localparam int K_LB = 0, K_LBU = 1, K_LH = 2, K_LHU = 3, K_LW = 4,
                 K_LWL = 5, K_LWR = 6, K_NONE = 7, K_ALU = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_EXE_MEM = 1'b0;
  logic        ready_MEM;
  logic        MemEn_EXE_MEM = 1'b0, MemToReg_EXE_MEM = 1'b0;
  logic [3:0]  RegWrite_EXE_MEM = 4'h0;
  logic [4:0]  RegWaddr_EXE_MEM = 5'd0;
  logic [31:0] ALUResult_EXE_MEM = 32'h0, RegRdata2_EXE_MEM = 32'h0;
  logic        LB_EXE_MEM = 1'b0, LBU_EXE_MEM = 1'b0, LH_EXE_MEM = 1'b0, LHU_EXE_MEM = 1'b0;
  logic [1:0]  LW_EXE_MEM = 2'b00;
  logic        data_rvalid = 1'b0;
  logic [31:0] data_rdata = 32'h0;
  logic        valid_MEM_WB;
  logic [3:0]  RegWrite_MEM_WB;
  logic [4:0]  RegWaddr_MEM_WB;
  logic [31:0] RegWdata_MEM_WB;
  logic        load_pending_MEM;
  logic [4:0]  PendWaddr_MEM;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  memory_load_stage dut (
    .clk(clk), .rst(rst),
    .valid_EXE_MEM(valid_EXE_MEM), .ready_MEM(ready_MEM),
    .MemEn_EXE_MEM(MemEn_EXE_MEM), .MemToReg_EXE_MEM(MemToReg_EXE_MEM),
    .RegWrite_EXE_MEM(RegWrite_EXE_MEM), .RegWaddr_EXE_MEM(RegWaddr_EXE_MEM),
    .ALUResult_EXE_MEM(ALUResult_EXE_MEM), .RegRdata2_EXE_MEM(RegRdata2_EXE_MEM),
    .LB_EXE_MEM(LB_EXE_MEM), .LBU_EXE_MEM(LBU_EXE_MEM),
    .LH_EXE_MEM(LH_EXE_MEM), .LHU_EXE_MEM(LHU_EXE_MEM), .LW_EXE_MEM(LW_EXE_MEM),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .valid_MEM_WB(valid_MEM_WB), .RegWrite_MEM_WB(RegWrite_MEM_WB),
    .RegWaddr_MEM_WB(RegWaddr_MEM_WB), .RegWdata_MEM_WB(RegWdata_MEM_WB),
    .load_pending_MEM(load_pending_MEM), .PendWaddr_MEM(PendWaddr_MEM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Alignment written as shifts and masks over the whole word.
  task automatic model_load(input int k, input logic [1:0] off, input logic [31:0] m,
                            input logic [31:0] rt, output logic [31:0] d, output logic [3:0] we);
    int s;
    s  = 8 * int'(off);
    we = 4'hF;
    d  = m;
    case (k)
      K_LB, K_LBU: begin
        d = (m >> s) & 32'hFF;
        if (k == K_LB && d[7]) d = d | 32'hFFFF_FF00;
      end
      K_LH, K_LHU: begin
        d = (m >> s) & 32'hFFFF;
        if (k == K_LH && d[15]) d = d | 32'hFFFF_0000;
      end
      K_LWL: begin
        s  = 8 * (3 - int'(off));
        d  = (m << s) | (rt & ((32'h1 << s) - 32'h1));
        we = 4'hF << (3 - int'(off));
      end
      K_LWR: begin
        d  = (m >> s) | (rt & ~(32'hFFFF_FFFF >> s));
        we = 4'hF >> off;
      end
      default: d = m;
    endcase
  endtask

  // Transaction model: at most one load outstanding.
  bit          m_pend;
  logic        m_v;
  logic [3:0]  m_we;
  logic [4:0]  m_wa, m_pwa;
  logic [31:0] m_wd;
  int          cur_kind = K_ALU;
  int          p_kind;
  logic [1:0]  p_off;
  logic [31:0] p_rt;

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 0; m_v = 0; m_we = 0; m_wa = 0; m_wd = 0; m_pwa = 0;
    end else if (!m_pend) begin
      m_v = 0;
      if (valid_EXE_MEM) begin
        if (MemEn_EXE_MEM && MemToReg_EXE_MEM) begin
          m_pend = 1;
          p_kind = cur_kind;
          p_off  = ALUResult_EXE_MEM[1:0];
          p_rt   = RegRdata2_EXE_MEM;
          m_pwa  = RegWaddr_EXE_MEM;
        end else begin
          m_v  = 1;
          m_we = RegWrite_EXE_MEM;
          m_wa = RegWaddr_EXE_MEM;
          m_wd = ALUResult_EXE_MEM;
        end
      end
    end else begin
      m_v = 0;
      if (data_rvalid) begin
        model_load(p_kind, p_off, data_rdata, p_rt, m_wd, m_we);
        m_wa   = m_pwa;
        m_v    = 1;
        m_pend = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc ready", {31'h0, ready_MEM}, {31'h0, !m_pend});
      chk("cyc pending", {31'h0, load_pending_MEM}, {31'h0, m_pend});
      chk("cyc pend_waddr", {27'h0, PendWaddr_MEM}, {27'h0, m_pwa});
      chk("cyc valid", {31'h0, valid_MEM_WB}, {31'h0, m_v});
      chk("cyc we", {28'h0, RegWrite_MEM_WB}, {28'h0, m_we});
      chk("cyc waddr", {27'h0, RegWaddr_MEM_WB}, {27'h0, m_wa});
      chk("cyc wdata", RegWdata_MEM_WB, m_wd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int k, input logic [4:0] wa, input logic [31:0] addr,
                        input logic [31:0] rt, input logic [3:0] we);
    cur_kind          = k;
    valid_EXE_MEM     = 1'b1;
    MemEn_EXE_MEM     = (k != K_ALU);
    MemToReg_EXE_MEM  = (k != K_ALU);
    RegWrite_EXE_MEM  = we;
    RegWaddr_EXE_MEM  = wa;
    ALUResult_EXE_MEM = addr;
    RegRdata2_EXE_MEM = rt;
    LB_EXE_MEM        = (k == K_LB);
    LBU_EXE_MEM       = (k == K_LBU);
    LH_EXE_MEM        = (k == K_LH);
    LHU_EXE_MEM       = (k == K_LHU);
    LW_EXE_MEM        = (k == K_LW) ? 2'b11 : (k == K_LWL) ? 2'b10 : (k == K_LWR) ? 2'b01 : 2'b00;
  endtask

  task automatic set_idle();
    valid_EXE_MEM    = 1'b0;
    MemEn_EXE_MEM    = 1'b0;
    MemToReg_EXE_MEM = 1'b0;
  endtask

  task automatic do_load(input int k, input logic [4:0] wa, input logic [31:0] addr,
                         input logic [31:0] rt, input logic [31:0] m, input int waitc);
    set_in(k, wa, addr, rt, 4'h0);
    tick();
    set_idle();
    for (int i = 0; i < waitc; i++) begin
      chk("wait ready_low", {31'h0, ready_MEM}, 32'h0);
      tick();
    end
    data_rvalid = 1'b1;
    data_rdata  = m;
    tick();
    data_rvalid = 1'b0;
    data_rdata  = 32'h5A5A_A5A5;
  endtask

  task automatic expect_wb(input string name, input logic [31:0] wd, input logic [3:0] we,
                           input logic [4:0] wa);
    bit seen = 0;
    for (int i = 0; i < 3 && !seen; i++) begin
      @(negedge clk);
      if (valid_MEM_WB === 1'b1) seen = 1;
    end
    chk({name, " valid"}, {31'h0, seen}, 32'h1);
    if (seen) begin
      chk({name, " wdata"}, RegWdata_MEM_WB, wd);
      chk({name, " we"}, {28'h0, RegWrite_MEM_WB}, {28'h0, we});
      chk({name, " waddr"}, {27'h0, RegWaddr_MEM_WB}, {27'h0, wa});
      chk({name, " model"}, m_wd, wd);
    end
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b1;
    tick();
    chk_en = 1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset ready", {31'h0, ready_MEM}, 32'h1);
    chk("reset pending", {31'h0, load_pending_MEM}, 32'h0);
    chk("reset valid", {31'h0, valid_MEM_WB}, 32'h0);
    chk("reset wdata", RegWdata_MEM_WB, 32'h0);
    chk("reset pend_waddr", {27'h0, PendWaddr_MEM}, 32'h0);

    set_in(K_ALU, 5'd5, 32'h1234_5678, 32'h0, 4'hF);
    tick();
    set_idle();
    chk("nonload ready", {31'h0, ready_MEM}, 32'h1);
    expect_wb("nonload", 32'h1234_5678, 4'hF, 5'd5);

    do_load(K_LB, 5'd7, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 2);
    expect_wb("lb off3", 32'hFFFF_FF80, 4'hF, 5'd7);
    do_load(K_LBU, 5'd8, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 2);
    expect_wb("lbu off3", 32'h0000_0080, 4'hF, 5'd8);
    do_load(K_LB, 5'd9, 32'h0000_1000, 32'h0, 32'h80AA_BBCC, 0);
    expect_wb("lb off0", 32'hFFFF_FFCC, 4'hF, 5'd9);
    do_load(K_LH, 5'd10, 32'h0000_2002, 32'h0, 32'h8001_1234, 1);
    expect_wb("lh off2", 32'hFFFF_8001, 4'hF, 5'd10);
    do_load(K_LHU, 5'd11, 32'h0000_2000, 32'h0, 32'h8001_1234, 0);
    expect_wb("lhu off0", 32'h0000_1234, 4'hF, 5'd11);
    do_load(K_LWL, 5'd12, 32'h0000_3001, 32'h1122_3344, 32'hAABB_CCDD, 1);
    expect_wb("lwl off1", 32'hCCDD_3344, 4'b1100, 5'd12);
    do_load(K_LWL, 5'd13, 32'h0000_3003, 32'h1122_3344, 32'hAABB_CCDD, 0);
    expect_wb("lwl off3", 32'hAABB_CCDD, 4'b1111, 5'd13);
    do_load(K_LWR, 5'd14, 32'h0000_3002, 32'h1122_3344, 32'hAABB_CCDD, 1);
    expect_wb("lwr off2", 32'h1122_AABB, 4'b0011, 5'd14);
    do_load(K_LWR, 5'd15, 32'h0000_3003, 32'h1122_3344, 32'hAABB_CCDD, 0);
    expect_wb("lwr off3", 32'h1122_33AA, 4'b0001, 5'd15);
    do_load(K_LW, 5'd16, 32'h0000_4000, 32'h0, 32'hDEAD_0001, 0);
    expect_wb("lw", 32'hDEAD_0001, 4'hF, 5'd16);
    do_load(K_NONE, 5'd17, 32'h0000_4001, 32'h0, 32'h0BAD_F00D, 0);
    expect_wb("noflag as lw", 32'h0BAD_F00D, 4'hF, 5'd17);

    // stray response while idle
    tick();
    data_rvalid = 1'b1;
    data_rdata  = 32'hFFFF_FFFF;
    tick();
    data_rvalid = 1'b0;
    @(negedge clk);
    chk("stray valid", {31'h0, valid_MEM_WB}, 32'h0);
    chk("stray wdata held", RegWdata_MEM_WB, 32'h0BAD_F00D);

    // load then non-load held during the wait
    tick();
    set_in(K_LW, 5'd20, 32'h0000_0100, 32'h0, 4'h0);
    tick();
    set_in(K_ALU, 5'd21, 32'hDEAD_BEEF, 32'h0, 4'b0011);
    data_rvalid = 1'b1;
    data_rdata  = 32'hCAFE_F00D;
    tick();
    data_rvalid = 1'b0;
    @(negedge clk);
    chk("b2b load valid", {31'h0, valid_MEM_WB}, 32'h1);
    chk("b2b load wdata", RegWdata_MEM_WB, 32'hCAFE_F00D);
    tick();
    set_idle();
    @(negedge clk);
    chk("b2b alu valid", {31'h0, valid_MEM_WB}, 32'h1);
    chk("b2b alu wdata", RegWdata_MEM_WB, 32'hDEAD_BEEF);
    chk("b2b alu we", {28'h0, RegWrite_MEM_WB}, 32'h3);

    // reset aborts an outstanding load
    tick();
    set_in(K_LB, 5'd25, 32'h0000_5001, 32'h0, 4'h0);
    tick();
    set_idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'h1234_5678;
    tick();
    data_rvalid = 1'b0;
    tick();
    chk("abort valid", {31'h0, valid_MEM_WB}, 32'h0);
    chk("abort ready", {31'h0, ready_MEM}, 32'h1);
    chk("abort pending", {31'h0, load_pending_MEM}, 32'h0);
    chk("abort wdata", RegWdata_MEM_WB, 32'h0);
    chk("abort pend_waddr", {27'h0, PendWaddr_MEM}, 32'h0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
